msx_ram_arbiter: RTL and testbench



---
 rtl/msx_ram_arbiter_pkg.sv | 21 ++
 rtl/msx_ram_slot_timer.sv | 29 ++
 rtl/msx_ram_arbiter.sv | 178 +++++++++++++++++
 tb/tb_msx_ram_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/msx_ram_arbiter_pkg.sv
// Shared RAM arbitration types: arbiter state encoding and turnaround length.
// No logic; imported by the arbiter and its slot timer.
// Backpressure: not applicable.
package msx_ram_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOST = 2'd1,
        ST_LOAD = 2'd2,
        ST_GAP  = 2'd3
    } arb_state_t;

    // Bus turnaround between owners; also the slot where a deferred refresh is issued.
    localparam int GAP_CYCLES = 1;

    // Counter width able to hold ACCESS_CYCLES-1 (ACCESS_CYCLES >= 2).
    function automatic int slot_cnt_width(input int access_cycles);
        return (access_cycles > 2) ? $clog2(access_cycles) : 1;
    endfunction

endpackage

// File: rtl/msx_ram_slot_timer.sv
// Loadable down-counter timing one loader RAM slot; tc is high in the slot's last cycle.
// Latency: load takes effect on the next CLK edge; tc is combinational from count.
// Backpressure: none; counts while run is high and parks at zero.
module msx_ram_slot_timer #(
    parameter int CNT_W = 2
) (
    input  logic             CLK,
    input  logic             RESET_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             run,
    output logic             tc
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (run && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign tc = run && (count == '0);

endmodule

// File: rtl/msx_ram_arbiter.sv
// Shares one RAM port between the cartridge (absolute priority) and a background loader.
// Latency: cartridge 0 cycles when idle, worst case ACCESS_CYCLES+1; loader ACCESS_CYCLES to L_ACK.
// Backpressure: cartridge stalled via H_WAIT; loader held by L_REQ until the one-cycle L_ACK.
module msx_ram_arbiter
    import msx_ram_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH    = 23,
    parameter int ACCESS_CYCLES = 4
) (
    input  logic                  CLK,
    input  logic                  RESET_n,
    input  logic [ADDR_WIDTH-1:0] H_ADDR,
    input  logic [7:0]            H_DIN,
    input  logic                  H_WE_n,
    input  logic                  H_OE_n,
    input  logic                  H_RFSH_n,
    output logic [7:0]            H_DOUT,
    output logic                  H_WAIT,
    input  logic                  L_REQ,
    input  logic                  L_WE,
    input  logic [ADDR_WIDTH-1:0] L_ADDR,
    input  logic [7:0]            L_WDATA,
    output logic                  L_ACK,
    output logic [7:0]            L_RDATA,
    output logic [ADDR_WIDTH-1:0] R_ADDR,
    output logic [7:0]            R_DIN,
    output logic                  R_WE_n,
    output logic                  R_OE_n,
    output logic                  R_RFSH_n,
    input  logic [7:0]            R_DOUT
);

    localparam int CNT_W = slot_cnt_width(ACCESS_CYCLES);

    arb_state_t            state;
    arb_state_t            next_state;
    logic                  host_act;
    logic                  load_start;
    logic                  slot_done;
    logic [ADDR_WIDTH-1:0] ld_addr;
    logic [7:0]            ld_wdata;
    logic                  ld_we;
    logic                  rfsh_pend;
    logic                  l_ack_q;
    logic [7:0]            l_rdata_q;
    logic                  h_wait_q;

    assign host_act = !H_WE_n || !H_OE_n;

    // GAP takes IDLE's loader decision on its exit edge so back-to-back
    // loads cost ACCESS_CYCLES+1; a waiting host still goes through IDLE first.
    assign load_start = ((state == ST_IDLE) || (state == ST_GAP)) && !host_act && L_REQ;

    msx_ram_slot_timer #(
        .CNT_W (CNT_W)
    ) u_slot_timer (
        .CLK      (CLK),
        .RESET_n  (RESET_n),
        .load     (load_start),
        .load_val (CNT_W'(ACCESS_CYCLES - 1)),
        .run      (state == ST_LOAD),
        .tc       (slot_done)
    );

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (host_act) begin
                    next_state = ST_HOST;
                end else if (L_REQ) begin
                    next_state = ST_LOAD;
                end
            end
            ST_HOST: begin
                if (!host_act) begin
                    next_state = ST_GAP;
                end
            end
            ST_LOAD: begin
                if (slot_done) begin
                    next_state = ST_GAP;
                end
            end
            ST_GAP: begin
                if (load_start) begin
                    next_state = ST_LOAD;
                end else begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        R_ADDR   = '0;
        R_DIN    = '0;
        R_WE_n   = 1'b1;
        R_OE_n   = 1'b1;
        R_RFSH_n = H_RFSH_n;
        H_DOUT   = '0;
        case (state)
            ST_IDLE: begin
                if (host_act) begin
                    R_ADDR = H_ADDR;
                    R_DIN  = H_DIN;
                    R_WE_n = H_WE_n;
                    R_OE_n = H_OE_n;
                end
            end
            ST_HOST: begin
                R_ADDR = H_ADDR;
                R_DIN  = H_DIN;
                R_WE_n = H_WE_n;
                R_OE_n = H_OE_n;
                if (!H_OE_n) begin
                    H_DOUT = R_DOUT;
                end
            end
            ST_LOAD: begin
                R_ADDR   = ld_addr;
                R_DIN    = ld_wdata;
                R_WE_n   = !ld_we;
                R_OE_n   = ld_we;
                R_RFSH_n = 1'b1;
            end
            ST_GAP: begin
                if (rfsh_pend) begin
                    R_RFSH_n = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Loader latch, completion, registered wait and deferred-refresh bookkeeping.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            ld_addr   <= '0;
            ld_wdata  <= '0;
            ld_we     <= 1'b0;
            l_ack_q   <= 1'b0;
            l_rdata_q <= '0;
            h_wait_q  <= 1'b0;
            rfsh_pend <= 1'b0;
        end else begin
            if (load_start) begin
                ld_addr  <= L_ADDR;
                ld_wdata <= L_WDATA;
                ld_we    <= L_WE;
            end
            l_ack_q <= slot_done;
            if (slot_done && !ld_we) begin
                l_rdata_q <= R_DOUT;
            end
            h_wait_q <= host_act && ((next_state == ST_LOAD) || (next_state == ST_GAP));
            if ((state == ST_LOAD) && !H_RFSH_n) begin
                rfsh_pend <= 1'b1;
            end else if (state == ST_GAP) begin
                rfsh_pend <= 1'b0;
            end
        end
    end

    assign L_ACK   = l_ack_q;
    assign L_RDATA = l_rdata_q;
    assign H_WAIT  = h_wait_q;

endmodule

// File: tb/tb_msx_ram_arbiter.sv
// Self-checking bench: directed scenarios plus randomized host/loader traffic
// against a timeline model of bus ownership.
module tb_msx_ram_arbiter;

    localparam int AW = 23;
    localparam int AC = 4;

    logic          CLK = 1'b0;
    logic          RESET_n = 1'b0;
    logic [AW-1:0] H_ADDR;
    logic [7:0]    H_DIN;
    logic          H_WE_n;
    logic          H_OE_n;
    logic          H_RFSH_n;
    logic [7:0]    H_DOUT;
    logic          H_WAIT;
    logic          L_REQ;
    logic          L_WE;
    logic [AW-1:0] L_ADDR;
    logic [7:0]    L_WDATA;
    logic          L_ACK;
    logic [7:0]    L_RDATA;
    logic [AW-1:0] R_ADDR;
    logic [7:0]    R_DIN;
    logic          R_WE_n;
    logic          R_OE_n;
    logic          R_RFSH_n;
    logic [7:0]    R_DOUT;

    msx_ram_arbiter #(
        .ADDR_WIDTH    (AW),
        .ACCESS_CYCLES (AC)
    ) dut (
        .CLK      (CLK),
        .RESET_n  (RESET_n),
        .H_ADDR   (H_ADDR),
        .H_DIN    (H_DIN),
        .H_WE_n   (H_WE_n),
        .H_OE_n   (H_OE_n),
        .H_RFSH_n (H_RFSH_n),
        .H_DOUT   (H_DOUT),
        .H_WAIT   (H_WAIT),
        .L_REQ    (L_REQ),
        .L_WE     (L_WE),
        .L_ADDR   (L_ADDR),
        .L_WDATA  (L_WDATA),
        .L_ACK    (L_ACK),
        .L_RDATA  (L_RDATA),
        .R_ADDR   (R_ADDR),
        .R_DIN    (R_DIN),
        .R_WE_n   (R_WE_n),
        .R_OE_n   (R_OE_n),
        .R_RFSH_n (R_RFSH_n),
        .R_DOUT   (R_DOUT)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Ownership timeline: loader owns [ld_start, ld_start+AC), turnaround at gap_at.
    int            cyc = 0;
    int            ld_start;
    int            gap_at;
    bit            host_own;
    bit            pend;
    logic [AW-1:0] m_addr;
    logic [7:0]    m_wdata;
    bit            m_we;
    bit            e_ack;
    logic [7:0]    e_rdata;
    bit            e_wait;

    task automatic model_reset();
        ld_start = -1;
        gap_at   = -1;
        host_own = 1'b0;
        pend     = 1'b0;
        m_addr   = '0;
        m_wdata  = '0;
        m_we     = 1'b0;
        e_ack    = 1'b0;
        e_rdata  = '0;
        e_wait   = 1'b0;
    endtask

    task automatic start_load();
        ld_start = cyc + 1;
        m_addr   = L_ADDR;
        m_wdata  = L_WDATA;
        m_we     = L_WE;
    endtask

    task automatic check_regs();
        check_val("l_ack", L_ACK, e_ack);
        check_val("l_rdata", L_RDATA, e_rdata);
        check_val("h_wait", H_WAIT, e_wait);
    endtask

    task automatic check_comb_and_advance();
        bit            hact;
        bit            in_load;
        bit            in_gap;
        logic [AW-1:0] ea;
        logic [7:0]    ed;
        logic [7:0]    eo;
        bit            ewe;
        bit            eoe;
        bit            erf;
        hact    = !H_WE_n || !H_OE_n;
        in_load = (ld_start >= 0) && (cyc >= ld_start) && (cyc < ld_start + AC);
        in_gap  = (cyc == gap_at);
        ea = '0; ed = '0; eo = '0; ewe = 1'b1; eoe = 1'b1; erf = H_RFSH_n;
        if (in_load) begin
            ea = m_addr; ed = m_wdata; ewe = !m_we; eoe = m_we; erf = 1'b1;
        end else if (in_gap) begin
            if (pend) erf = 1'b0;
        end else if (host_own || hact) begin
            ea = H_ADDR; ed = H_DIN; ewe = H_WE_n; eoe = H_OE_n;
            if (host_own && !H_OE_n) eo = R_DOUT;
        end
        check_val("r_addr", R_ADDR, ea);
        check_val("r_din", R_DIN, ed);
        check_val("r_we_n", R_WE_n, ewe);
        check_val("r_oe_n", R_OE_n, eoe);
        check_val("r_rfsh_n", R_RFSH_n, erf);
        check_val("h_dout", H_DOUT, eo);
        e_ack  = 1'b0;
        e_wait = hact && in_load;
        if (in_load) begin
            if (!H_RFSH_n) pend = 1'b1;
            if (cyc == ld_start + AC - 1) begin
                e_ack = 1'b1;
                if (!m_we) e_rdata = R_DOUT;
                gap_at = cyc + 1;
            end
        end else if (in_gap) begin
            pend = 1'b0;
            if (!hact && L_REQ) start_load();
        end else if (host_own) begin
            if (!hact) begin
                host_own = 1'b0;
                gap_at   = cyc + 1;
            end
        end else if (hact) begin
            host_own = 1'b1;
        end else if (L_REQ) begin
            start_load();
        end
        cyc++;
    endtask

    task automatic begin_cycle();
        @(negedge CLK);
        check_regs();
    endtask

    task automatic end_cycle();
        #1;
        check_comb_and_advance();
    endtask

    task automatic set_idle();
        H_ADDR = '0; H_DIN = '0; H_WE_n = 1'b1; H_OE_n = 1'b1; H_RFSH_n = 1'b1;
        L_REQ = 1'b0; L_WE = 1'b0; L_ADDR = '0; L_WDATA = '0; R_DOUT = '0;
    endtask

    task automatic new_req();
        L_REQ   = 1'b1;
        L_WE    = 1'($urandom_range(0, 1));
        L_ADDR  = AW'($urandom);
        L_WDATA = 8'($urandom);
    endtask

    initial begin
        int cnt_a;
        int cnt_b;
        int at;
        int h_left;
        logic v;
        model_reset();
        set_idle();
        #2;
        check_val("rst_r_we_n", R_WE_n, 1);
        check_val("rst_r_oe_n", R_OE_n, 1);
        check_val("rst_r_rfsh_n", R_RFSH_n, 1);
        check_val("rst_r_addr", R_ADDR, 0);
        check_val("rst_r_din", R_DIN, 0);
        check_val("rst_l_ack", L_ACK, 0);
        check_val("rst_l_rdata", L_RDATA, 0);
        check_val("rst_h_wait", H_WAIT, 0);
        check_val("rst_h_dout", H_DOUT, 0);
        @(negedge CLK);
        RESET_n = 1'b1;
        end_cycle();

        // Host read from idle: same-cycle passthrough, data returned while owned.
        begin_cycle();
        H_OE_n = 1'b0; H_ADDR = 23'h12345; R_DOUT = 8'hA5;
        end_cycle();
        check_val("t1_addr", R_ADDR, 23'h12345);
        check_val("t1_oe", R_OE_n, 0);
        cnt_a = int'(H_WAIT);
        begin_cycle(); end_cycle();
        check_val("t1_dout", H_DOUT, 8'hA5);
        cnt_a += int'(H_WAIT);
        begin_cycle(); H_OE_n = 1'b1; end_cycle();
        for (int i = 0; i < 3; i++) begin
            begin_cycle(); cnt_a += int'(H_WAIT); end_cycle();
        end
        check_val("t1_wait", cnt_a, 0);

        // Loader read in idle.
        begin_cycle();
        L_REQ = 1'b1; L_WE = 1'b0; L_ADDR = 23'h4000; R_DOUT = 8'h3C;
        end_cycle();
        cnt_a = 0; cnt_b = 0; at = -1; v = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            begin_cycle();
            if (L_ACK) begin L_REQ = 1'b0; cnt_b++; at = i; end
            end_cycle();
            if (!R_OE_n) cnt_a++;
            if (i == AC + 1) v = R_WE_n & R_OE_n & R_RFSH_n;
        end
        check_val("t2_oe_cycles", cnt_a, AC);
        check_val("t2_ack_count", cnt_b, 1);
        check_val("t2_ack_at", at, AC + 1);
        check_val("t2_rdata", L_RDATA, 8'h3C);
        check_val("t2_gap_strobes", v, 1);

        // Host write arrives in LOAD cycle 2 of a loader write.
        begin_cycle();
        L_REQ = 1'b1; L_WE = 1'b1; L_ADDR = 23'h100; L_WDATA = 8'h5A;
        end_cycle();
        cnt_a = 0; at = -1;
        for (int i = 1; i <= 10; i++) begin
            begin_cycle();
            cnt_a += int'(H_WAIT);
            if (L_ACK) L_REQ = 1'b0;
            if (i == 2) begin H_WE_n = 1'b0; H_DIN = 8'h77; H_ADDR = 23'h200; end
            if (i == 8) H_WE_n = 1'b1;
            end_cycle();
            if (at < 0 && !R_WE_n && R_DIN == 8'h77 && !H_WAIT) at = i;
        end
        check_val("t3_wait_cycles", cnt_a, 3);
        check_val("t3_host_served", at, AC + 2);

        // Host and loader request together: host first, loader after release.
        begin_cycle();
        H_OE_n = 1'b0; H_ADDR = 23'h3333; L_REQ = 1'b1; L_WE = 1'b0; L_ADDR = 23'h55;
        end_cycle();
        check_val("t4_grant", R_ADDR, 23'h3333);
        for (int i = 0; i < 3; i++) begin begin_cycle(); end_cycle(); end
        begin_cycle(); H_OE_n = 1'b1; end_cycle();
        at = -1;
        for (int i = 1; i <= 10; i++) begin
            begin_cycle();
            if (L_ACK && at < 0) begin at = i; L_REQ = 1'b0; end
            end_cycle();
        end
        check_val("t4_ack_after_release", at - 1, AC + 1);

        // Refresh requested during LOAD is deferred into the turnaround cycle.
        begin_cycle();
        L_REQ = 1'b1; L_WE = 1'b0; L_ADDR = 23'h777;
        end_cycle();
        cnt_a = 0; v = 1'b1; cnt_b = 0;
        for (int i = 1; i <= 7; i++) begin
            begin_cycle();
            if (L_ACK) L_REQ = 1'b0;
            H_RFSH_n = (i == 1) ? 1'b0 : 1'b1;
            end_cycle();
            if (i <= AC && !R_RFSH_n) cnt_a++;
            if (i == AC + 1) v = R_RFSH_n;
            if (i == AC + 2) cnt_b = int'(R_RFSH_n);
        end
        check_val("t5_rfsh_in_load", cnt_a, 0);
        check_val("t5_rfsh_gap", v, 0);
        check_val("t5_rfsh_after", cnt_b, 1);

        // Asynchronous reset in LOAD cycle 2.
        begin_cycle();
        L_REQ = 1'b1; L_WE = 1'b1; L_ADDR = 23'h999; L_WDATA = 8'h11;
        end_cycle();
        begin_cycle(); end_cycle();
        begin_cycle(); end_cycle();
        #2 RESET_n = 1'b0;
        #1;
        check_val("t6_we_n", R_WE_n, 1);
        check_val("t6_oe_n", R_OE_n, 1);
        check_val("t6_rfsh_n", R_RFSH_n, 1);
        check_val("t6_addr", R_ADDR, 0);
        model_reset();
        L_REQ = 1'b0;
        @(negedge CLK);
        check_regs();
        RESET_n = 1'b1;
        end_cycle();
        cnt_a = 0;
        for (int i = 0; i < 6; i++) begin
            begin_cycle(); cnt_a += int'(L_ACK); end_cycle();
        end
        check_val("t6_no_ack", cnt_a, 0);
        begin_cycle();
        L_REQ = 1'b1; L_WE = 1'b0; L_ADDR = 23'h1234; R_DOUT = 8'hC3;
        end_cycle();
        at = -1;
        for (int i = 1; i <= 7; i++) begin
            begin_cycle();
            if (L_ACK && at < 0) begin at = i; L_REQ = 1'b0; end
            end_cycle();
        end
        check_val("t6_fresh_ack_at", at, AC + 1);
        check_val("t6_fresh_rdata", L_RDATA, 8'hC3);

        // Randomized mixed traffic.
        h_left = 0;
        for (int c = 0; c < 2000; c++) begin
            begin_cycle();
            if (L_ACK) begin
                if ($urandom_range(0, 1) == 1) new_req();
                else L_REQ = 1'b0;
            end else if (!L_REQ && $urandom_range(0, 3) == 0) begin
                new_req();
            end
            if (h_left > 0) begin
                h_left--;
            end else begin
                H_WE_n = 1'b1; H_OE_n = 1'b1;
                if ($urandom_range(0, 3) == 0) begin
                    h_left = $urandom_range(0, 5);
                    if ($urandom_range(0, 1) == 1) H_WE_n = 1'b0;
                    else H_OE_n = 1'b0;
                    H_ADDR = AW'($urandom);
                    H_DIN  = 8'($urandom);
                end
            end
            H_RFSH_n = ($urandom_range(0, 7) != 0);
            R_DOUT   = 8'($urandom);
            end_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
